// File: rtl/dvi_chunk_drawer.sv
// ============================================================================
// Module   : dvi_chunk_drawer
// Brief    : Streams R/G/B pixels from two ping-pong chunk buffers fetched from
//            frame RAM; shows a fill colour and flags underrun when data is late.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvi_chunk_drawer #(
    parameter int                  PIX_BITS        = 24,
    parameter int                  CHUNK_PIX       = 256,
    parameter int                  CHUNKS_PER_LINE = 5,
    parameter logic [PIX_BITS-1:0] FILL_COLOR      = 24'h000000
) (
    input  logic                                  pixel_clock,
    input  logic                                  reset,
    input  logic                                  ram_init,
    input  logic                                  new_frame,
    input  logic                                  new_line,
    input  logic                                  pixel_enable,
    output logic                                  ask_data,
    output logic [((CHUNKS_PER_LINE > 1) ? $clog2(CHUNKS_PER_LINE) : 1)-1:0] req_chunk,
    input  logic                                  ram_ack,
    input  logic [PIX_BITS*CHUNK_PIX-1:0]         read_data,
    output logic [PIX_BITS/3-1:0]                 R,
    output logic [PIX_BITS/3-1:0]                 G,
    output logic [PIX_BITS/3-1:0]                 B,
    output logic                                  underrun
);

    localparam int CW        = (CHUNKS_PER_LINE > 1) ? $clog2(CHUNKS_PER_LINE) : 1;
    localparam int PW        = (CHUNK_PIX > 1) ? $clog2(CHUNK_PIX) : 1;
    localparam int CB        = PIX_BITS / 3;
    localparam int LINE_BITS = PIX_BITS * CHUNK_PIX;

    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS_PER_LINE - 1);
    localparam logic [PW-1:0] LAST_PIX   = PW'(CHUNK_PIX - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]           state;
    logic                 stale;
    logic                 restart;
    logic [PW-1:0]        pix;
    logic [CW-1:0]        chunk;
    logic [1:0]           buf_full;
    logic [CW-1:0]        buf_tag  [2];
    logic [LINE_BITS-1:0] buf_data [2];

    logic                 line_evt;
    logic [PW-1:0]        eff_pix;
    logic [CW-1:0]        eff_chunk;
    logic                 pix_last;
    logic                 chunk_end;
    logic [PW-1:0]        pix_nxt;
    logic [CW-1:0]        chunk_nxt;
    logic                 hit0;
    logic                 hit1;
    logic                 hit;
    logic [LINE_BITS-1:0] cur_data;
    logic [LINE_BITS-1:0] shifted;
    logic [PIX_BITS-1:0]  pix_word;
    logic [1:0]           free_mask;
    logic [1:0]           full_nxt;
    logic                 stale_evt;
    logic                 ack_ok;
    logic                 discard;
    logic                 accept;
    logic                 wr_idx;
    logic                 any_free;
    logic                 frame_restart;

    function automatic logic [CW-1:0] inc_chunk(input logic [CW-1:0] c);
        return (c == LAST_CHUNK) ? '0 : c + CW'(1);
    endfunction

    // A line/frame start overrides the counters for the pixel drawn in that cycle.
    always_comb begin
        line_evt  = new_line | new_frame;
        eff_pix   = line_evt ? '0 : pix;
        eff_chunk = line_evt ? '0 : chunk;
        pix_last  = (eff_pix == LAST_PIX);
        chunk_end = pixel_enable && pix_last;
        pix_nxt   = eff_pix;
        chunk_nxt = eff_chunk;
        if (pixel_enable) begin
            pix_nxt = pix_last ? '0 : eff_pix + PW'(1);
            if (pix_last) begin
                chunk_nxt = inc_chunk(eff_chunk);
            end
        end
    end

    always_comb begin
        hit0     = buf_full[0] && (buf_tag[0] == eff_chunk);
        hit1     = buf_full[1] && (buf_tag[1] == eff_chunk);
        hit      = hit0 | hit1;
        cur_data = hit0 ? buf_data[0] : buf_data[1];
        shifted  = cur_data << (PIX_BITS * int'(eff_pix));
        pix_word = shifted[LINE_BITS-1 -: PIX_BITS];
    end

    // A buffer is released when its slot ends, or on a line start unless it holds chunk 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            free_mask[i] = buf_full[i] &&
                           ((chunk_end && (buf_tag[i] == eff_chunk)) ||
                            (line_evt && (buf_tag[i] != '0)));
        end
        stale_evt     = (state == S_REQ) &&
                        ((chunk_end && (req_chunk == eff_chunk)) ||
                         (line_evt && (req_chunk != '0)));
        frame_restart = restart || (new_frame && (req_chunk != '0));
        ack_ok        = (state == S_REQ) && ram_ack;
        discard       = stale || stale_evt;
        accept        = ack_ok && !discard;
        wr_idx        = buf_full[0];
        any_free      = ~(buf_full[0] & buf_full[1]);
        full_nxt      = buf_full & ~free_mask;
        if (accept) begin
            full_nxt[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state      <= S_IDLE;
            ask_data   <= 1'b0;
            req_chunk  <= '0;
            stale      <= 1'b0;
            restart    <= 1'b0;
            pix        <= '0;
            chunk      <= '0;
            buf_full   <= '0;
            buf_tag[0] <= '0;
            buf_tag[1] <= '0;
            underrun   <= 1'b0;
            R          <= '0;
            G          <= '0;
            B          <= '0;
        end else begin
            pix      <= pix_nxt;
            chunk    <= chunk_nxt;
            buf_full <= full_nxt;
            if (accept) begin
                buf_tag[wr_idx] <= req_chunk;
            end

            if (pixel_enable) begin
                if (hit) begin
                    R <= pix_word[PIX_BITS-1 -: CB];
                    G <= pix_word[2*CB-1 -: CB];
                    B <= pix_word[CB-1:0];
                end else begin
                    R <= FILL_COLOR[PIX_BITS-1 -: CB];
                    G <= FILL_COLOR[2*CB-1 -: CB];
                    B <= FILL_COLOR[CB-1:0];
                end
            end else begin
                R <= '0;
                G <= '0;
                B <= '0;
            end

            if (pixel_enable && !hit) begin
                underrun <= 1'b1;
            end else if (new_frame) begin
                underrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (new_frame) begin
                        req_chunk <= '0;
                    end
                    if (ram_init && any_free) begin
                        state    <= S_REQ;
                        ask_data <= 1'b1;
                        stale    <= 1'b0;
                        restart  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (stale_evt) begin
                        stale <= 1'b1;
                    end
                    // A chunk-0 fetch already in flight is itself the frame restart.
                    if (new_frame && (req_chunk != '0)) begin
                        restart <= 1'b1;
                    end
                    if (ram_ack) begin
                        state    <= S_IDLE;
                        ask_data <= 1'b0;
                        if (frame_restart) begin
                            req_chunk <= '0;
                        end else if (discard) begin
                            req_chunk <= inc_chunk(chunk_nxt);
                        end else begin
                            req_chunk <= inc_chunk(req_chunk);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ask_data <= 1'b0;
                end
            endcase
        end
    end

    // Chunk payloads carry no reset; validity lives in buf_full.
    always_ff @(posedge pixel_clock) begin
        if (accept) begin
            buf_data[wr_idx] <= read_data;
        end
    end

endmodule

`default_nettype wire
